tsc_serial_tx: RTL and testbench
================================

# tsc_serial_tx

Serial transmitter stage directly downstream of the TSC trigger/stream controller. It accepts one captured byte at a time on the TSC's send-data strobe and serializes it as an asynchronous frame: start bit, 8 data bits LSB first, optional even parity, stop bit. When a frame completes, it returns the one-cycle `SBF` (send buffer free) handshake that the TSC waits on before presenting the next ring-buffer byte.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit; legal range 2..65535; divider width 16.
- `PARITY_EN`, default 0: 1 inserts an even-parity bit between data and stop.
- `clk`  input  1  system clock; all state changes on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `SD`  input  1  send-data strobe from TSC; one-cycle pulse, data valid in same cycle.
- `data_in`  input  8  byte to transmit, sampled when `SD`=1 is accepted.
- `clr_overrun`  input  1  synchronous clear of `overrun`.
- `tx`  output  1  serial line, idle high.
- `SBF`  output  1  one-cycle pulse: frame finished, ready for next byte.
- `busy`  output  1  high while a frame is in progress.
- `overrun`  output  1  sticky: `SD` arrived while busy.
- `state_out`  output  3  current FSM state, for bench observation.

## Operation
- States: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; codes 5–7 are unused and recover to IDLE on the next edge.
- IDLE: `tx`=1 and `busy`=0. `SD`=1 latches `data_in` into the shift register, clears the bit and divider counters, and moves to START.
- START: drive `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA: drive `tx`=shift[0] for `CLKS_PER_BIT` cycles per bit, then shift right. After the 8th bit, go to PARITY if `PARITY_EN`=1, else to STOP.
- PARITY: drive `tx` = XOR of the latched byte (even parity) for `CLKS_PER_BIT` cycles, then go to STOP.
- STOP: drive `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE and assert `SBF` for exactly one cycle.
- `SD` while not IDLE: the byte is discarded, the current frame is unaffected, and `overrun` is set.
- `overrun` is cleared by `clr_overrun` or `reset`. If set and clear coincide, set wins.
- `SD` in the same cycle `SBF` is high: accepted, giving back-to-back frames with no idle bit.
- Divider: counts 0..`CLKS_PER_BIT`-1 and wraps at the bit boundary. The bit counter counts 0..7.

## Timing
- Reset values, asserted asynchronously: `tx`=1, `SBF`=0, `busy`=0, `overrun`=0, `state_out`=0; shift register and counters cleared.
- Reset mid-frame: `tx` returns to 1 immediately. No `SBF` is produced, and the partial frame is abandoned.
- Let edge E0 be the edge where `SD`=1 is sampled:
  - `tx` falls and `busy` rises in the cycle after E0 (cycle 1).
  - Start bit occupies cycles 1..N, where N=`CLKS_PER_BIT`.
  - Data bit k occupies cycles (k+1)N+1..(k+2)N.
  - Stop bit occupies cycles 9N+1..10N; with parity enabled, parity takes 9N+1..10N and stop 10N+1..11N.
- `SBF`=1 in cycle 10N+1 (11N+1 with parity); `busy`=0 in that same cycle.
- Frame latency from E0 to `SBF`: 10N+1 cycles (11N+1 with parity).
- `data_in` changes after E0 do not affect the frame in progress.

## Test plan
- Reset, then N=4, `PARITY_EN`=0, `SD` with 0xA5 -> `tx` bits 0,1,0,1,0,0,1,0,1,1, each held 4 cycles in cycles 1–40; `SBF` high only in cycle 41; `busy` high cycles 1–40.
- `PARITY_EN`=1, bytes 0x07 and 0xA5 -> parity bit 1 for 0x07 and 0 for 0xA5 in cycles 37–40; `SBF` in cycle 45.
- `SD` with 0x3C at cycle 10 of a 0xA5 frame -> 0xA5 frame bit-exact, `overrun`=1 and stays set; `clr_overrun` pulse clears it the next cycle.
- `SD` with 0x81 in the `SBF` cycle -> start bit of 0x81 begins in the next cycle with no idle gap; second `SBF` arrives 41 cycles after the first.
- `reset` pulse at cycle 20 mid-frame -> `tx`=1, `busy`=0, `state_out`=0 immediately; no `SBF`; a new `SD` after reset transmits correctly.
- TSC handshake loop: feed 32 bytes on `SD` only after each `SBF` -> 32 frames decoded equal to the sent bytes, `overrun` remains 0.

Source files
------------

// File: rtl/tsc_serial_tx.sv
// Async-frame serializer behind the TSC: start, 8 data LSB-first, optional even parity, stop; SBF on completion.
// States: IDLE=0 wait for SD | START=1 start bit | DATA=2 data bits | PARITY=3 even parity | STOP=4 stop bit
module tsc_serial_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SD,
  input  logic [7:0] data_in,
  input  logic       clr_overrun,
  output logic       tx,
  output logic       SBF,
  output logic       busy,
  output logic       overrun,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_q, bit_d;
  logic [15:0] div_q, div_d;
  logic        par_q, par_d;
  logic        sbf_q, sbf_d;
  logic        ovr_q, ovr_d;
  logic        bit_end;

  assign bit_end = (div_q == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      par_q   <= 1'b0;
      sbf_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      par_q   <= par_d;
      sbf_q   <= sbf_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    div_d   = div_q;
    par_d   = par_q;
    sbf_d   = 1'b0;
    if (state_q != IDLE) begin
      div_d = bit_end ? 16'd0 : div_q + 16'd1;
    end
    case (state_q)
      IDLE: begin
        if (SD) begin
          shift_d = data_in;
          par_d   = ^data_in;
          bit_d   = 3'd0;
          div_d   = 16'd0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = PARITY_EN ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          sbf_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A late SD is dropped; set takes priority over a coincident clear.
  always_comb begin
    ovr_d = ovr_q;
    if (SD && (state_q != IDLE)) ovr_d = 1'b1;
    else if (clr_overrun)        ovr_d = 1'b0;
  end

  always_comb begin
    tx = 1'b1;
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = shift_q[0];
      PARITY:  tx = par_q;
      default: tx = 1'b1;
    endcase
  end

  assign SBF       = sbf_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = ovr_q;
  assign state_out = state_q;

endmodule

// File: tb/tb_tsc_serial_tx.sv
// Bench for tsc_serial_tx: one instance without parity, one with; frames checked cycle by cycle against a bit-list model.
module tb_tsc_serial_tx;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr;
  logic       sd0, sd1;
  logic [7:0] d0, d1;
  logic       tx0, sbf0, busy0, ovr0;
  logic       tx1, sbf1, busy1, ovr1;
  logic [2:0] st0, st1;
  int         checks = 0;
  int         failures = 0;
  logic       exp_ovr0;

  always #5 clk = ~clk;

  tsc_serial_tx #(.CLKS_PER_BIT(N), .PARITY_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .SD(sd0), .data_in(d0), .clr_overrun(clr),
    .tx(tx0), .SBF(sbf0), .busy(busy0), .overrun(ovr0), .state_out(st0));

  tsc_serial_tx #(.CLKS_PER_BIT(N), .PARITY_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .SD(sd1), .data_in(d1), .clr_overrun(clr),
    .tx(tx1), .SBF(sbf1), .busy(busy1), .overrun(ovr1), .state_out(st1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input int sel, input logic [7:0] b);
    @(negedge clk);
    if (sel == 0) begin sd0 = 1'b1; d0 = b; end
    else          begin sd1 = 1'b1; d1 = b; end
  endtask

  // Model: the frame is a list of bits, each held N cycles; SBF lands one cycle after the list ends.
  task automatic frame(input int sel, input logic [7:0] b, input int inj, input int abort,
                       input bit chain, input logic [7:0] nb);
    int         len;
    int         last;
    int         idx;
    logic [7:0] rx;
    logic       etx, otx, osbf, obusy;
    logic [2:0] est, ost;
    len  = (sel != 0) ? 11 : 10;
    last = len * N + 1;
    rx   = 8'h00;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      sd0 = 1'b0;
      sd1 = 1'b0;
      if (c == 1) begin d0 = 8'($urandom); d1 = 8'($urandom); end
      if (c == abort) begin
        reset = 1'b1;
        #1;
        chk("abort_tx", 32'(tx0), 32'd1);
        chk("abort_busy", 32'(busy0), 32'd0);
        chk("abort_state", 32'(st0), 32'd0);
        chk("abort_sbf", 32'(sbf0), 32'd0);
        exp_ovr0 = 1'b0;
        return;
      end
      idx = (c - 1) / N;
      if (c == last)                      begin etx = 1'b1;       est = 3'd0; end
      else if (idx == 0)                  begin etx = 1'b0;       est = 3'd1; end
      else if (idx <= 8)                  begin etx = b[idx - 1]; est = 3'd2; end
      else if ((sel != 0) && (idx == 9))  begin etx = ^b;         est = 3'd3; end
      else                                begin etx = 1'b1;       est = 3'd4; end
      if (sel == 0) begin otx = tx0; osbf = sbf0; obusy = busy0; ost = st0; end
      else          begin otx = tx1; osbf = sbf1; obusy = busy1; ost = st1; end
      chk($sformatf("tx d%0d c%0d", sel, c), 32'(otx), 32'(etx));
      chk($sformatf("state d%0d c%0d", sel, c), 32'(ost), 32'(est));
      chk($sformatf("busy d%0d c%0d", sel, c), 32'(obusy), (c == last) ? 32'd0 : 32'd1);
      chk($sformatf("sbf d%0d c%0d", sel, c), 32'(osbf), (c == last) ? 32'd1 : 32'd0);
      if (sel == 0) chk($sformatf("ovr c%0d", c), 32'(ovr0), 32'(exp_ovr0));
      if (idx >= 1 && idx <= 8 && ((c - 1) % N) == N / 2) rx[idx - 1] = otx;
      if (sel == 0 && c == inj) begin
        sd0 = 1'b1;
        d0 = 8'h3C;
        exp_ovr0 = 1'b1;
      end
      if (chain && c == last) begin
        if (sel == 0) begin sd0 = 1'b1; d0 = nb; end
        else          begin sd1 = 1'b1; d1 = nb; end
      end
    end
    chk($sformatf("decode d%0d", sel), 32'(rx), 32'(b));
  endtask

  initial begin
    logic [7:0] b;
    reset = 1'b1; clr = 1'b0; sd0 = 1'b0; sd1 = 1'b0; d0 = 8'h00; d1 = 8'h00;
    exp_ovr0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx0", 32'(tx0), 32'd1);
    chk("rst_sbf0", 32'(sbf0), 32'd0);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_ovr0", 32'(ovr0), 32'd0);
    chk("rst_st0", 32'(st0), 32'd0);
    chk("rst_tx1", 32'(tx1), 32'd1);
    chk("rst_sbf1", 32'(sbf1), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_ovr1", 32'(ovr1), 32'd0);
    chk("rst_st1", 32'(st1), 32'd0);
    reset = 1'b0;

    start(0, 8'hA5); frame(0, 8'hA5, 0, 0, 1'b0, 8'h00);

    start(1, 8'h07); frame(1, 8'h07, 0, 0, 1'b0, 8'h00);
    start(1, 8'hA5); frame(1, 8'hA5, 0, 0, 1'b0, 8'h00);
    chk("par_ovr1", 32'(ovr1), 32'd0);

    start(0, 8'hA5); frame(0, 8'hA5, 10, 0, 1'b0, 8'h00);
    @(negedge clk);
    chk("ovr_held", 32'(ovr0), 32'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("ovr_cleared", 32'(ovr0), 32'd0);
    exp_ovr0 = 1'b0;

    start(0, 8'hA5); frame(0, 8'hA5, 0, 0, 1'b1, 8'h81);
    frame(0, 8'h81, 0, 0, 1'b0, 8'h00);

    start(0, 8'hA5); frame(0, 8'hA5, 0, 20, 1'b0, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_sbf %0d", i), 32'(sbf0), 32'd0);
      chk($sformatf("post_rst_tx %0d", i), 32'(tx0), 32'd1);
    end
    start(0, 8'h5A); frame(0, 8'h5A, 0, 0, 1'b0, 8'h00);

    for (int i = 0; i < 32; i++) begin
      b = 8'($urandom);
      start(0, b);
      frame(0, b, 0, 0, 1'b0, 8'h00);
    end
    chk("loop_ovr", 32'(ovr0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
